id_ex_register: RTL

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// id_ex_register
// ID/EX pipeline register with bubble insertion and halt-drain control.
//
// Each rising edge either captures the decode-stage instruction into the
// EX-stage registers or inserts a bubble. A bubble clears ex_valid and the
// ten control bits. The datapath and register-index fields keep their old
// values, because nothing downstream uses them while ex_valid is low.
//
// A halting ECALL (id_is_ecall with halt_req) is captured like any other
// instruction. The block then enters DRAIN and inserts bubbles for three
// edges so that older instructions can leave the pipe. After that it sits
// in HALTED until reset.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   id_*              decode-stage control bits, datapath values, reg indices
//   id_valid          decode slot holds a real instruction
//   halt_req          decoded ECALL requests a halt (x17 == 10)
//   stall             load-use hazard: insert a bubble into EX
//   flush             redirect: kill the ID-stage instruction
//   ex_*              registered EX-stage copies of the id_* inputs
//   draining          halt drain in progress
//   is_halted         pipeline drained after a halting ECALL
module id_ex_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_mem_read,
  input  logic        id_mem_to_reg,
  input  logic        id_mem_write,
  input  logic        id_alu_src,
  input  logic        id_write_enable,
  input  logic        id_pc_to_reg,
  input  logic        id_is_jal,
  input  logic        id_is_jalr,
  input  logic        id_branch,
  input  logic        id_is_ecall,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_op,
  input  logic        id_valid,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_mem_read,
  output logic        ex_mem_to_reg,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_write_enable,
  output logic        ex_pc_to_reg,
  output logic        ex_is_jal,
  output logic        ex_is_jalr,
  output logic        ex_branch,
  output logic        ex_is_ecall,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_valid,
  output logic        is_halted,
  output logic        draining
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state_reg;
  logic [1:0] drain_cnt_reg;
  logic       load_en;

  // draining and is_halted are registers, so this path starts only at
  // flops and inputs. No input reaches an output without a clock edge.
  // Because DRAIN and HALTED block load_en, stall and flush have no
  // effect in those states.
  assign load_en = id_valid & ~stall & ~flush & ~draining & ~is_halted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_read     <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_write_enable <= 1'b0;
      ex_pc_to_reg    <= 1'b0;
      ex_is_jal       <= 1'b0;
      ex_is_jalr      <= 1'b0;
      ex_branch       <= 1'b0;
      ex_is_ecall     <= 1'b0;
      ex_pc           <= '0;
      ex_rs1_data     <= '0;
      ex_rs2_data     <= '0;
      ex_imm          <= '0;
      ex_rs1          <= '0;
      ex_rs2          <= '0;
      ex_rd           <= '0;
      ex_alu_op       <= '0;
      ex_valid        <= 1'b0;
      state_reg       <= RUN;
      drain_cnt_reg   <= 2'd0;
      draining        <= 1'b0;
      is_halted       <= 1'b0;
    end else begin
      if (load_en) begin
        ex_mem_read     <= id_mem_read;
        ex_mem_to_reg   <= id_mem_to_reg;
        ex_mem_write    <= id_mem_write;
        ex_alu_src      <= id_alu_src;
        ex_write_enable <= id_write_enable;
        ex_pc_to_reg    <= id_pc_to_reg;
        ex_is_jal       <= id_is_jal;
        ex_is_jalr      <= id_is_jalr;
        ex_branch       <= id_branch;
        ex_is_ecall     <= id_is_ecall;
        ex_pc           <= id_pc;
        ex_rs1_data     <= id_rs1_data;
        ex_rs2_data     <= id_rs2_data;
        ex_imm          <= id_imm;
        ex_rs1          <= id_rs1;
        ex_rs2          <= id_rs2;
        ex_rd           <= id_rd;
        ex_alu_op       <= id_alu_op;
        ex_valid        <= 1'b1;
      end else begin
        // Bubble: kill all side effects but leave the datapath fields alone.
        ex_mem_read     <= 1'b0;
        ex_mem_to_reg   <= 1'b0;
        ex_mem_write    <= 1'b0;
        ex_alu_src      <= 1'b0;
        ex_write_enable <= 1'b0;
        ex_pc_to_reg    <= 1'b0;
        ex_is_jal       <= 1'b0;
        ex_is_jalr      <= 1'b0;
        ex_branch       <= 1'b0;
        ex_is_ecall     <= 1'b0;
        ex_valid        <= 1'b0;
      end

      case (state_reg)
        RUN: begin
          if (load_en && id_is_ecall && halt_req) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 2'd0;
            draining      <= 1'b1;
          end
        end
        DRAIN: begin
          // The counter reads 0, 1, 2 on the three edges after the ECALL
          // is captured. The edge that sees 2 enters HALTED.
          drain_cnt_reg <= drain_cnt_reg + 2'd1;
          if (drain_cnt_reg == 2'd2) begin
            state_reg <= HALTED;
            draining  <= 1'b0;
            is_halted <= 1'b1;
          end
        end
        HALTED: begin
          state_reg <= HALTED;
        end
        default: begin
          state_reg <= RUN;
          draining  <= 1'b0;
          is_halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
